pwm_compare: RTL and testbench
==============================

# pwm_compare

PWM output stage sitting directly downstream of the prescaled period counter. Each cycle it compares the counter value against double-buffered compare registers and drives the registered `pwm_out` waveform in left-aligned, right-aligned or unaligned mode. Compare values and mode written by the register file are held pending and become active only at a period boundary, so output periods are never truncated.

## Interface
- `WIDTH`, 16, width of counter, period and compare values
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pwm_en`  in  1  output enable; 0 forces `pwm_out` low
- `count_val`  in  WIDTH  current counter value
- `period`  in  WIDTH  counter period (same value the counter uses)
- `upnotdown`  in  1  counter direction, 1 = up
- `cfg_wr`  in  1  one-cycle strobe: capture `compare1`, `compare2`, `functions` into pending
- `compare1`  in  WIDTH  first compare value
- `compare2`  in  WIDTH  second compare value (unaligned mode only)
- `functions`  in  2  mode: bit1=1 unaligned; else bit0=0 left, bit0=1 right aligned
- `pwm_out`  out  1  PWM waveform, registered
- `period_done`  out  1  one-cycle pulse per period boundary
- `upd_pending`  out  1  pending config not yet transferred to active

## Operation
- Registers: `prev_count`, pending {cmp1, cmp2, func}, active {cmp1, cmp2, func}, `upd_pending`, `pwm_out`, `period_done`.
- Boundary (combinational, cycle N): up: `prev_count==period && count_val==0`; down: `prev_count==0 && count_val==period`. Prescaler hold cycles never match (count unchanged).
- `period==0`: no boundary is generated; pending transfers to active on the cycle after `cfg_wr`; `pwm_out` forced 0.
- `pwm_en==0`: pending transfers on the cycle after `cfg_wr`; `pwm_out` 0.
- Effective config E = (boundary && upd_pending) ? pending : active; used for the compare in the boundary cycle itself, so the first count of a new period already uses new values.
- Compare on `count_val` with E (unsigned, WIDTH bits):
  - left: high when `count_val < cmp1`; cmp1=0 -> always 0; cmp1>period -> always 1.
  - right: high when `count_val >= cmp1`; cmp1=0 -> always 1.
  - unaligned: high when `cmp1 <= count_val < cmp2`; cmp1>=cmp2 -> always 0.
- `cfg_wr`: pending <= inputs, `upd_pending` <= 1. A second write before the boundary overwrites pending.
- Transfer: active <= pending, `upd_pending` <= 0.
- `cfg_wr` in the same cycle as boundary: existing pending transfers now; new write lands in pending, `upd_pending` stays 1 until next boundary.
- Mode change mid-period impossible by construction (active changes only at boundary / when disabled).

## Timing
- Reset: `pwm_out`=0, `period_done`=0, `upd_pending`=0, all compare/func registers 0, `prev_count`=0.
- `pwm_out` latency: 1 cycle after `count_val`.
- `period_done`: high exactly the cycle after boundary detection, for one cycle; also while `pwm_en`=0 if counter still moves.
- `upd_pending` rises the cycle after `cfg_wr`, falls the cycle after transfer.
- Reset asserted mid-period: outputs drop immediately; pending write lost.

## Structure
- Shared package `pwm_pkg`: `FUNC_LEFT=2'b00`, `FUNC_RIGHT=2'b01`, `FUNC_UNALIGNED=2'b1x` decode, WIDTH default.
- One sub-module natural: `pwm_boundary_det` (prev_count register + boundary/period_done logic), reusable by interrupt logic.

## Test plan
- Up, period=9, prescale 0, left, cmp1=3 -> `pwm_out` high 3 of 10 cycles, delayed 1 cycle from count; `period_done` every 10 cycles.
- Right, cmp1=0 -> constant 1; left, cmp1=0 -> constant 0; left, cmp1=12, period=9 -> constant 1.
- Unaligned cmp1=2, cmp2=6, period=9 -> high for counts 2..5; cmp1=6, cmp2=2 -> constant 0.
- Write cmp1=7 at count 4 -> `upd_pending`=1, old duty finishes, new duty starts at count 0; write coinciding with boundary -> applied one period later.
- Down count, period=9, left cmp1=3 -> boundary at 0->9, high for counts 2..0 each period.
- `pwm_en`=0 with `cfg_wr` -> active updated next cycle, `pwm_out`=0; assert `rst_n` mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: compare-mode encodings,
// default datapath width and the mode decode helper.
package pwm_pkg;

   localparam int WIDTH_DEF = 16;

   // functions[1] set selects unaligned regardless of functions[0]
   localparam logic [1:0] FUNC_LEFT      = 2'b00;
   localparam logic [1:0] FUNC_RIGHT     = 2'b01;
   localparam logic [1:0] FUNC_UNALIGNED = 2'b10;

   typedef enum logic [1:0] {
      MODE_LEFT      = 2'd0,
      MODE_RIGHT     = 2'd1,
      MODE_UNALIGNED = 2'd2
   } pwm_mode_e;

   function automatic pwm_mode_e decode_func(input logic [1:0] func);
      pwm_mode_e mode;
      mode = MODE_LEFT;
      if (func[1]) begin
         mode = MODE_UNALIGNED;
      end else if (func[0]) begin
         mode = MODE_RIGHT;
      end
      return mode;
   endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// Configuration bus between the register file (master) and the PWM compare
// stage (slave). cfg_wr is a single-cycle strobe with no back-pressure: the
// slave always accepts it, and upd_pending reports a write not yet in effect.
interface pwm_compare_if #(
   parameter int WIDTH = 16
);

   logic             cfg_wr;
   logic [WIDTH-1:0] compare1;
   logic [WIDTH-1:0] compare2;
   logic [1:0]       functions;
   logic             upd_pending;

   modport master (
      output cfg_wr,
      output compare1,
      output compare2,
      output functions,
      input  upd_pending
   );

   modport slave (
      input  cfg_wr,
      input  compare1,
      input  compare2,
      input  functions,
      output upd_pending
   );

endinterface

// File: rtl/pwm_boundary_det.sv
// Period boundary detector: remembers the previous counter value and flags the
// wrap (period->0 counting up, 0->period counting down), plus a registered pulse.
module pwm_boundary_det #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] count_val,
   input  logic [WIDTH-1:0] period,
   input  logic             upnotdown,
   output logic             boundary,
   output logic             period_done
);

   logic [WIDTH-1:0] prev_count_q, prev_count_d;
   logic             period_done_q, period_done_d;
   logic             wrap_up;
   logic             wrap_down;

   // A zero period never wraps; prescaler hold cycles leave prev==count and miss both tests.
   always_comb begin
      prev_count_d  = count_val;
      wrap_up       = (prev_count_q == period) && (count_val == '0);
      wrap_down     = (prev_count_q == '0) && (count_val == period);
      boundary      = 1'b0;
      if (period != '0) begin
         boundary = upnotdown ? wrap_up : wrap_down;
      end
      period_done_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_count_q  <= '0;
         period_done_q <= 1'b0;
      end else begin
         prev_count_q  <= prev_count_d;
         period_done_q <= period_done_d;
      end
   end

   assign period_done = period_done_q;

endmodule

// File: rtl/pwm_compare.sv
// PWM output stage: double-buffered compare/mode registers that switch only at
// a period boundary (or immediately when idle), and a registered compare output.
module pwm_compare
   import pwm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_en,
   input  logic [WIDTH-1:0] count_val,
   input  logic [WIDTH-1:0] period,
   input  logic             upnotdown,
   pwm_compare_if.slave     cfg,
   output logic             pwm_out,
   output logic             period_done
);

   logic [WIDTH-1:0] pend_cmp1_q, pend_cmp1_d;
   logic [WIDTH-1:0] pend_cmp2_q, pend_cmp2_d;
   logic [1:0]       pend_func_q, pend_func_d;
   logic [WIDTH-1:0] act_cmp1_q,  act_cmp1_d;
   logic [WIDTH-1:0] act_cmp2_q,  act_cmp2_d;
   logic [1:0]       act_func_q,  act_func_d;
   logic             upd_pending_q, upd_pending_d;
   logic             pwm_out_q, pwm_out_d;

   logic             boundary;
   logic             xfer;
   logic [WIDTH-1:0] eff_cmp1;
   logic [WIDTH-1:0] eff_cmp2;
   logic [1:0]       eff_func;
   pwm_mode_e        eff_mode;
   logic             hit;

   pwm_boundary_det #(
      .WIDTH (WIDTH)
   ) u_boundary_det (
      .clk         (clk),
      .rst_n       (rst_n),
      .count_val   (count_val),
      .period      (period),
      .upnotdown   (upnotdown),
      .boundary    (boundary),
      .period_done (period_done)
   );

   // While the output is idle there is no period to protect, so transfer at once.
   always_comb begin
      xfer = upd_pending_q && (boundary || (period == '0) || !pwm_en);
   end

   // Pending values steer the boundary cycle itself so count 0 of the new period uses them.
   always_comb begin
      eff_cmp1 = act_cmp1_q;
      eff_cmp2 = act_cmp2_q;
      eff_func = act_func_q;
      if (boundary && upd_pending_q) begin
         eff_cmp1 = pend_cmp1_q;
         eff_cmp2 = pend_cmp2_q;
         eff_func = pend_func_q;
      end
      eff_mode = decode_func(eff_func);
   end

   always_comb begin
      hit = 1'b0;
      case (eff_mode)
         MODE_LEFT:      hit = (count_val < eff_cmp1);
         MODE_RIGHT:     hit = (count_val >= eff_cmp1);
         MODE_UNALIGNED: hit = (count_val >= eff_cmp1) && (count_val < eff_cmp2);
         default:        hit = 1'b0;
      endcase
      pwm_out_d = pwm_en && (period != '0) && hit;
   end

   // A write coinciding with a transfer lands in pending and keeps the flag set.
   always_comb begin
      pend_cmp1_d   = pend_cmp1_q;
      pend_cmp2_d   = pend_cmp2_q;
      pend_func_d   = pend_func_q;
      act_cmp1_d    = act_cmp1_q;
      act_cmp2_d    = act_cmp2_q;
      act_func_d    = act_func_q;
      upd_pending_d = upd_pending_q;
      if (xfer) begin
         act_cmp1_d    = pend_cmp1_q;
         act_cmp2_d    = pend_cmp2_q;
         act_func_d    = pend_func_q;
         upd_pending_d = 1'b0;
      end
      if (cfg.cfg_wr) begin
         pend_cmp1_d   = cfg.compare1;
         pend_cmp2_d   = cfg.compare2;
         pend_func_d   = cfg.functions;
         upd_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cmp1_q   <= '0;
         pend_cmp2_q   <= '0;
         pend_func_q   <= FUNC_LEFT;
         act_cmp1_q    <= '0;
         act_cmp2_q    <= '0;
         act_func_q    <= FUNC_LEFT;
         upd_pending_q <= 1'b0;
         pwm_out_q     <= 1'b0;
      end else begin
         pend_cmp1_q   <= pend_cmp1_d;
         pend_cmp2_q   <= pend_cmp2_d;
         pend_func_q   <= pend_func_d;
         act_cmp1_q    <= act_cmp1_d;
         act_cmp2_q    <= act_cmp2_d;
         act_func_q    <= act_func_d;
         upd_pending_q <= upd_pending_d;
         pwm_out_q     <= pwm_out_d;
      end
   end

   assign pwm_out         = pwm_out_q;
   assign cfg.upd_pending = upd_pending_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: the bench drives the period counter itself and
// checks pwm_out / period_done / upd_pending against hand-written per-count masks.
module tb_pwm_compare;
   import pwm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        pwm_en;
   logic [15:0] count_val;
   logic [15:0] period;
   logic        upnotdown;
   logic        pwm_out;
   logic        period_done;

   int total;
   int bad;

   pwm_compare_if #(.WIDTH(16)) cif ();

   pwm_compare #(
      .WIDTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pwm_en      (pwm_en),
      .count_val   (count_val),
      .period      (period),
      .upnotdown   (upnotdown),
      .cfg         (cif.slave),
      .pwm_out     (pwm_out),
      .period_done (period_done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs set after this return are sampled at the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [15:0] c1, input logic [15:0] c2, input logic [1:0] f);
      cif.cfg_wr    = 1'b1;
      cif.compare1  = c1;
      cif.compare2  = c2;
      cif.functions = f;
      tick();
      cif.cfg_wr    = 1'b0;
   endtask

   // One up period 0..9; mask[c] is the expected pwm_out for count c.
   task automatic run_up_period(input logic [9:0] mask, input string tag, input int wr_at,
                                input logic [15:0] c1, input logic [15:0] c2, input logic [1:0] f);
      for (int c = 0; c <= 9; c++) begin
         count_val = 16'(c);
         if (c == wr_at) begin
            cif.cfg_wr    = 1'b1;
            cif.compare1  = c1;
            cif.compare2  = c2;
            cif.functions = f;
         end
         tick();
         cif.cfg_wr = 1'b0;
         chk(tag, pwm_out, mask[c]);
         chk({tag, "_pd"}, period_done, c == 0);
      end
   endtask

   task automatic run_down_period(input logic [9:0] mask, input string tag);
      for (int c = 9; c >= 0; c--) begin
         count_val = 16'(c);
         tick();
         chk(tag, pwm_out, mask[c]);
         chk({tag, "_pd"}, period_done, c == 9);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      pwm_en        = 1'b0;
      count_val     = '0;
      period        = 16'd9;
      upnotdown     = 1'b1;
      cif.cfg_wr    = 1'b0;
      cif.compare1  = '0;
      cif.compare2  = '0;
      cif.functions = FUNC_LEFT;

      tick();
      tick();
      chk("rst_pwm", pwm_out, 1'b0);
      chk("rst_pd", period_done, 1'b0);
      chk("rst_upd", cif.upd_pending, 1'b0);
      rst_n = 1'b1;
      pwm_en = 1'b1;
      tick();

      // left cmp1=3, applied at the first boundary
      cfg_write(16'd3, 16'd0, FUNC_LEFT);
      chk("upd_rise", cif.upd_pending, 1'b1);
      for (int c = 1; c <= 9; c++) begin
         count_val = 16'(c);
         tick();
         chk("prime_up", pwm_out, 1'b0);
      end
      run_up_period(10'b0000000111, "left3", -1, '0, '0, FUNC_LEFT);
      chk("upd_fall", cif.upd_pending, 1'b0);
      run_up_period(10'b0000000111, "left3_b", -1, '0, '0, FUNC_LEFT);

      // mid-period write: old duty finishes
      run_up_period(10'b0000000111, "left3_wr", 4, 16'd7, 16'd0, FUNC_LEFT);
      chk("upd_mid", cif.upd_pending, 1'b1);
      run_up_period(10'b0001111111, "left7", -1, '0, '0, FUNC_LEFT);
      chk("upd_left7", cif.upd_pending, 1'b0);

      // write coinciding with boundary while another write is pending
      run_up_period(10'b0001111111, "left7_wr", 5, 16'd5, 16'd0, FUNC_LEFT);
      run_up_period(10'b0000011111, "bnd_wr", 0, 16'd1, 16'd0, FUNC_LEFT);
      chk("upd_bnd", cif.upd_pending, 1'b1);
      run_up_period(10'b0000000001, "left1", -1, '0, '0, FUNC_LEFT);
      chk("upd_left1", cif.upd_pending, 1'b0);

      // corner compare values
      run_up_period(10'b0000000001, "left1_wr", 5, 16'd0, 16'd0, FUNC_RIGHT);
      run_up_period(10'b1111111111, "right0", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b1111111111, "right0_wr", 5, 16'd0, 16'd0, FUNC_LEFT);
      run_up_period(10'b0000000000, "left0", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b0000000000, "left0_wr", 5, 16'd12, 16'd0, FUNC_LEFT);
      run_up_period(10'b1111111111, "left12", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b1111111111, "left12_wr", 5, 16'd2, 16'd6, FUNC_UNALIGNED);
      run_up_period(10'b0000111100, "unal26", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b0000111100, "unal26_wr", 5, 16'd6, 16'd2, 2'b11);
      run_up_period(10'b0000000000, "unal62", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b0000000000, "unal62_wr", 5, 16'd3, 16'd0, FUNC_RIGHT);
      run_up_period(10'b1111111000, "right3", -1, '0, '0, FUNC_LEFT);
      run_up_period(10'b1111111000, "right3_wr", 5, 16'd3, 16'd0, FUNC_LEFT);
      run_up_period(10'b0000000111, "left3_c", -1, '0, '0, FUNC_LEFT);

      // down counting: wrap is 0 -> 9
      upnotdown = 1'b0;
      for (int c = 8; c >= 0; c--) begin
         count_val = 16'(c);
         tick();
         chk("prime_dn", pwm_out, c < 3);
         chk("prime_dn_pd", period_done, 1'b0);
      end
      run_down_period(10'b0000000111, "down_left3");
      run_down_period(10'b0000000111, "down_left3_b");

      // disabled: write takes effect without a boundary, output held low
      pwm_en = 1'b0;
      tick();
      chk("dis_pwm", pwm_out, 1'b0);
      cfg_write(16'd6, 16'd0, FUNC_LEFT);
      chk("dis_upd_rise", cif.upd_pending, 1'b1);
      chk("dis_pwm_b", pwm_out, 1'b0);
      tick();
      chk("dis_upd_fall", cif.upd_pending, 1'b0);
      count_val = 16'd9;
      tick();
      chk("dis_pd", period_done, 1'b1);
      chk("dis_pwm_c", pwm_out, 1'b0);
      count_val = 16'd5;
      pwm_en = 1'b1;
      tick();
      chk("en_left6_5", pwm_out, 1'b1);
      count_val = 16'd6;
      tick();
      chk("en_left6_6", pwm_out, 1'b0);

      // zero period: no boundary, immediate transfer, output low
      period = 16'd0;
      count_val = 16'd0;
      tick();
      chk("p0_pd", period_done, 1'b0);
      cfg_write(16'd2, 16'd0, FUNC_RIGHT);
      chk("p0_upd_rise", cif.upd_pending, 1'b1);
      tick();
      chk("p0_upd_fall", cif.upd_pending, 1'b0);
      chk("p0_pwm", pwm_out, 1'b0);

      // reset mid-period drops everything asynchronously
      period = 16'd9;
      upnotdown = 1'b1;
      count_val = 16'd5;
      tick();
      chk("pre_rst_pwm", pwm_out, 1'b1);
      cfg_write(16'd9, 16'd0, FUNC_LEFT);
      count_val = 16'd9;
      tick();
      count_val = 16'd0;
      tick();
      chk("pre_rst_pd", period_done, 1'b1);
      cfg_write(16'd8, 16'd0, FUNC_RIGHT);
      chk("pre_rst_upd", cif.upd_pending, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pwm", pwm_out, 1'b0);
      chk("arst_pd", period_done, 1'b0);
      chk("arst_upd", cif.upd_pending, 1'b0);
      #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         count_val = 16'(c);
         tick();
         chk("post_rst", pwm_out, 1'b0);
      end
      count_val = 16'd0;
      tick();
      chk("post_rst_pd", period_done, 1'b1);
      chk("post_rst_lost", pwm_out, 1'b0);
      chk("post_rst_upd", cif.upd_pending, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
